// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix add controller: lane width,
// default geometry, controller state encoding and the default word type.
package matrix_pkg;

  localparam int LANE_W           = 16;
  localparam int DEF_PARALLEL_NUM = 28;
  localparam int DEF_ADDR_W       = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_e;

  typedef logic [LANE_W*DEF_PARALLEL_NUM-1:0] word_t;

endpackage

// File: rtl/matrix_add_ctrl_if.sv
// Command, RAM and adder-set signals of the matrix add controller.
// master = controller side, slave = host / RAM / adder-set side.
interface matrix_add_ctrl_if
  import matrix_pkg::*;
#(
  parameter int PARALLEL_NUM = DEF_PARALLEL_NUM,
  parameter int ADDR_W       = DEF_ADDR_W
);

  localparam int DATA_W = LANE_W * PARALLEL_NUM;

  logic              start;
  logic [ADDR_W-1:0] baseA;
  logic [ADDR_W-1:0] baseB;
  logic [ADDR_W-1:0] baseC;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              rdEn;
  logic [ADDR_W-1:0] rdAddrA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataA;
  logic [DATA_W-1:0] rdDataB;
  logic [DATA_W-1:0] addaSet;
  logic [DATA_W-1:0] addbSet;
  logic [DATA_W-1:0] addabSet;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  modport master (
    input  start, baseA, baseB, baseC, len, rdDataA, rdDataB, addabSet,
    output busy, done, rdEn, rdAddrA, rdAddrB, addaSet, addbSet,
           wrEn, wrAddr, wrData
  );

  modport slave (
    output start, baseA, baseB, baseC, len, rdDataA, rdDataB, addabSet,
    input  busy, done, rdEn, rdAddrA, rdAddrB, addaSet, addbSet,
           wrEn, wrAddr, wrData
  );

endinterface

// File: rtl/matrix_add_pipe_valid.sv
// Two-stage valid/address delay line: stage 1 marks RAM data arrival,
// stage 2 is the write strobe and result address.
module matrix_add_pipe_valid #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  output logic              s1_valid_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      s2_valid_q <= s1_valid_q;
      // Addresses only advance with valid data so wrAddr holds between bursts.
      if (in_valid_i) s1_addr_q <= in_addr_i;
      if (s1_valid_q) s2_addr_q <= s1_addr_q;
    end
  end

  assign s1_valid_o  = s1_valid_q;
  assign out_valid_o = s2_valid_q;
  assign out_addr_o  = s2_addr_q;

endmodule

// File: rtl/matrix_add_ctrl.sv
// Sequences one element-wise C = A + B: streams len words from RAMs A/B
// through the external adder set and writes the registered sums to RAM C.
module matrix_add_ctrl
  import matrix_pkg::*;
#(
  parameter int PARALLEL_NUM = DEF_PARALLEL_NUM,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  matrix_add_ctrl_if.master  bus
);

  localparam int DATA_W = LANE_W * PARALLEL_NUM;
  localparam int LEN_W  = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [DATA_W-1:0] wr_data_q;
  logic              s1_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_en_d  = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d  = RUN;
            rd_en_d  = 1'b1;
            cnt_d    = bus.len - LEN_W'(1);
            addr_a_d = bus.baseA;
            addr_b_d = bus.baseB;
            addr_c_d = bus.baseC;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        // cnt_q counts reads still to issue after the one currently on the bus.
        if (cnt_q != '0) begin
          rd_en_d  = 1'b1;
          cnt_d    = cnt_q - LEN_W'(1);
          addr_a_d = addr_a_q + ADDR_W'(1);
          addr_b_d = addr_b_q + ADDR_W'(1);
          addr_c_d = addr_c_q + ADDR_W'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Once stage 1 is empty the final write retires on this edge.
        if (!s1_valid) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_en_q  <= rd_en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           wr_data_q <= '0;
    else if (s1_valid) wr_data_q <= bus.addabSet;
  end

  matrix_add_pipe_valid #(
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_en_q),
    .in_addr_i   (addr_c_q),
    .s1_valid_o  (s1_valid),
    .out_valid_o (wr_en),
    .out_addr_o  (wr_addr)
  );

  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == FIN);
  assign bus.rdEn    = rd_en_q;
  assign bus.rdAddrA = addr_a_q;
  assign bus.rdAddrB = addr_b_q;
  assign bus.addaSet = bus.rdDataA;
  assign bus.addbSet = bus.rdDataB;
  assign bus.wrEn    = wr_en;
  assign bus.wrAddr  = wr_addr;
  assign bus.wrData  = wr_data_q;

endmodule

// File: tb/tb_matrix_add_ctrl.sv
// Self-checking bench for matrix_add_ctrl: RAM and adder-set models, a write
// scoreboard, and per-cycle checks of the control timing.
module tb_matrix_add_ctrl;
  import matrix_pkg::*;

  localparam int PN    = DEF_PARALLEL_NUM;
  localparam int AW    = DEF_ADDR_W;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    word_t         data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_add_ctrl_if #(.PARALLEL_NUM(PN), .ADDR_W(AW)) bus ();

  matrix_add_ctrl #(.PARALLEL_NUM(PN), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t ram_a [DEPTH];
  word_t ram_b [DEPTH];
  word_t rd_a_q = '0;
  word_t rd_b_q = '0;

  always @(posedge clk) begin
    if (bus.rdEn) begin
      rd_a_q <= ram_a[bus.rdAddrA];
      rd_b_q <= ram_b[bus.rdAddrB];
    end
  end
  assign bus.rdDataA = rd_a_q;
  assign bus.rdDataB = rd_b_q;

  function automatic word_t adder_set(word_t a, word_t b);
    word_t r;
    for (int l = 0; l < PN; l++) r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
    return r;
  endfunction
  assign bus.addabSet = adder_set(bus.addaSet, bus.addbSet);

  // Reference sum computed in integer arithmetic, wrapped explicitly.
  function automatic word_t exp_word(word_t a, word_t b);
    word_t r;
    int    s;
    for (int l = 0; l < PN; l++) begin
      s = (int'(a[l*LANE_W +: LANE_W]) + int'(b[l*LANE_W +: LANE_W])) % 65536;
      r[l*LANE_W +: LANE_W] = 16'(s);
    end
    return r;
  endfunction

  int      checks = 0;
  int      errors = 0;
  wr_exp_t sb[$];
  word_t   last_wr_data;

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [AW:0] n);
    wr_exp_t e;
    @(negedge clk);
    bus.baseA = a;
    bus.baseB = b;
    bus.baseC = c;
    bus.len   = n;
    bus.start = 1'b1;
    for (int k = 0; k < int'(n); k++) begin
      e.addr = AW'(int'(c) + k);
      e.data = exp_word(ram_a[AW'(int'(a) + k)], ram_b[AW'(int'(b) + k)]);
      sb.push_back(e);
    end
  endtask

  task automatic check_cycle(input string tag, input int cyc, input logic [AW-1:0] a,
                             input logic [AW-1:0] b, input int n);
    logic [3:0]    got, exp;
    logic [AW-1:0] ea, eb;
    wr_exp_t       e;
    got = {bus.busy, bus.done, bus.rdEn, bus.wrEn};
    exp[3] = (n != 0) && (cyc <= n + 2);
    exp[2] = (n == 0) ? (cyc == 1) : (cyc == n + 3);
    exp[1] = (n != 0) && (cyc <= n);
    exp[0] = (n != 0) && (cyc >= 3) && (cyc <= n + 2);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ctrl cyc %0d busy/done/rdEn/wrEn got %b exp %b", tag, cyc, got, exp);
    end
    if (exp[1]) begin
      ea = AW'(int'(a) + cyc - 1);
      eb = AW'(int'(b) + cyc - 1);
      checks++;
      if (bus.rdAddrA !== ea || bus.rdAddrB !== eb) begin
        errors++;
        $display("FAIL %s rdaddr cyc %0d got A=%0d B=%0d exp A=%0d B=%0d",
                 tag, cyc, bus.rdAddrA, bus.rdAddrB, ea, eb);
      end
    end
    if (bus.wrEn === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected write cyc %0d addr %0d", tag, cyc, bus.wrAddr);
      end else begin
        e = sb.pop_front();
        last_wr_data = bus.wrData;
        if (bus.wrAddr !== e.addr || bus.wrData !== e.data) begin
          errors++;
          $display("FAIL %s write cyc %0d got addr %0d data %h exp addr %0d data %h",
                   tag, cyc, bus.wrAddr, bus.wrData, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c, input logic [AW:0] n, input int last_cyc,
                         input int extra1, input int extra2);
    issue(a, b, c, n);
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      check_cycle(tag, cyc, a, b, int'(n));
      bus.start = (cyc == extra1) || (cyc == extra2);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s writes missing got %0d pending exp 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bus.busy, bus.done, bus.rdEn, bus.wrEn} !== 4'b0 || bus.rdAddrA !== '0 ||
        bus.rdAddrB !== '0 || bus.wrAddr !== '0 || bus.wrData !== '0) begin
      errors++;
      $display("FAIL %s outputs got busy=%b done=%b rdEn=%b wrEn=%b rdA=%0d rdB=%0d wrA=%0d exp all 0",
               tag, bus.busy, bus.done, bus.rdEn, bus.wrEn, bus.rdAddrA, bus.rdAddrB, bus.wrAddr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    run_cmd("basic", 10'd0, 10'd16, 10'd32, 11'd4, 8, -1, -1);
  endtask

  task automatic test_overflow();
    ram_a[200] = {PN{16'hFFFF}};
    ram_b[300] = {PN{16'h0002}};
    run_cmd("overflow", 10'd200, 10'd300, 10'd400, 11'd1, 5, -1, -1);
    checks++;
    if (last_wr_data !== {PN{16'h0001}}) begin
      errors++;
      $display("FAIL overflow lanes got %h exp all 0001", last_wr_data);
    end
  endtask

  task automatic test_zero_len();
    run_cmd("zero_len", 10'd5, 10'd6, 10'd7, 11'd0, 5, -1, -1);
  endtask

  task automatic test_wrap();
    run_cmd("wrap", 10'd1022, 10'd5, 10'd1023, 11'd3, 7, -1, -1);
  endtask

  task automatic test_ignored_start();
    // Pulses in cycle 2 (RUN) and cycle 7 (FIN, coincident with done).
    run_cmd("ignored_start", 10'd40, 10'd60, 10'd80, 11'd4, 9, 2, 7);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_first", 10'd100, 10'd110, 10'd120, 11'd2, 5, -1, -1);
    run_cmd("b2b_second", 10'd130, 10'd140, 10'd150, 11'd3, 7, -1, -1);
  endtask

  task automatic test_reset_mid_run();
    issue(10'd0, 10'd100, 10'd500, 11'd8);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_run");
    rst = 1'b0;
    sb.delete();
    for (int cyc = 5; cyc <= 14; cyc++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.rdEn, bus.wrEn} !== 4'b0) begin
        errors++;
        $display("FAIL reset_quiet cyc %0d busy/done/rdEn/wrEn got %b exp 0000", cyc,
                 {bus.busy, bus.done, bus.rdEn, bus.wrEn});
      end
    end
    run_cmd("after_reset", 10'd300, 10'd310, 10'd320, 11'd5, 9, -1, -1);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.baseA = '0;
    bus.baseB = '0;
    bus.baseC = '0;
    bus.len   = '0;
    for (int x = 0; x < DEPTH; x++) begin
      for (int l = 0; l < PN; l++) begin
        ram_a[x][l*LANE_W +: LANE_W] = 16'(l + x);
        ram_b[x][l*LANE_W +: LANE_W] = 16'(100 + l + x);
      end
    end
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_wrap();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
